// File: rtl/uart_rx_frame_checker_pkg.sv
// Shared types and helpers for the UART RX frame checker: FSM states,
// word-length codes, latched frame configuration and parity rule.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Frame format captured on the start bit and held for the whole frame.
  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
  } rx_cfg_t;

  function automatic logic [3:0] data_bits(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 4'd5;
      WLS_6:   return 4'd6;
      WLS_7:   return 4'd7;
      default: return 4'd8;
    endcase
  endfunction

  // acc is the XOR of the data bits; stick parity forces the bit to ~eps.
  function automatic logic expected_parity(input logic sp, input logic eps,
                                           input logic acc);
    return sp ? ~eps : (eps ? acc : ~acc);
  endfunction

endpackage

// File: rtl/uart_rx_frame_checker_if.sv
// Bit-sampler side and LSR/FIFO side signals of the UART RX frame checker.
interface uart_rx_frame_checker_if #(
  parameter int MAX_DATA_W = 8,
  parameter int CNT_W      = 8
);
  logic                  bit_valid;
  logic                  bit_in;
  logic [1:0]            wls;
  logic                  stb;
  logic                  pen;
  logic                  eps;
  logic                  sp;
  logic                  cnt_clr;
  logic                  busy;
  logic                  frame_valid;
  logic [MAX_DATA_W-1:0] rx_data;
  logic                  parity_error;
  logic                  framing_error;
  logic                  break_int;
  logic [CNT_W-1:0]      pe_count;
  logic [CNT_W-1:0]      fe_count;

  modport master (
    output bit_valid, bit_in, wls, stb, pen, eps, sp, cnt_clr,
    input  busy, frame_valid, rx_data, parity_error, framing_error,
           break_int, pe_count, fe_count
  );

  modport slave (
    input  bit_valid, bit_in, wls, stb, pen, eps, sp, cnt_clr,
    output busy, frame_valid, rx_data, parity_error, framing_error,
           break_int, pe_count, fe_count
  );
endinterface

// File: rtl/uart_rx_frame_checker_err_sat_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module err_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Serial UART RX frame checker: walks start/data/parity/stop bits one strobe
// at a time and reports data plus parity, framing and break status per frame.
module uart_rx_frame_checker #(
  parameter int MAX_DATA_W = 8,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_rx_frame_checker_if.slave  bus
);
  import uart_rx_pkg::*;

  localparam int IDX_W = $clog2(MAX_DATA_W);

  rx_state_e             state;
  rx_cfg_t               cfg_q;
  logic [MAX_DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]      bit_cnt;
  logic                  acc_q;
  logic                  par_q;

  logic                  busy_q;
  logic                  fv_q;
  logic [MAX_DATA_W-1:0] data_q;
  logic                  pe_q;
  logic                  fe_q;
  logic                  bi_q;

  logic [IDX_W-1:0]      last_idx;
  logic                  exp_par;

  assign last_idx = IDX_W'(data_bits(cfg_q.wls) - 4'd1);
  assign exp_par  = expected_parity(cfg_q.sp, cfg_q.eps, acc_q);

  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge value of state, counters and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cfg_q   <= '0;
      shift_q <= '0;
      bit_cnt <= '0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      busy_q  <= 1'b0;
      fv_q    <= 1'b0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      bi_q    <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      if (bus.bit_valid) begin
        case (state)
          IDLE: begin
            if (!bus.bit_in) begin
              state   <= DATA;
              cfg_q   <= '{wls: bus.wls, stb: bus.stb, pen: bus.pen,
                           eps: bus.eps, sp: bus.sp};
              shift_q <= '0;
              bit_cnt <= '0;
              acc_q   <= 1'b0;
              par_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          DATA: begin
            shift_q[bit_cnt] <= bus.bit_in;
            acc_q            <= acc_q ^ bus.bit_in;
            bit_cnt          <= bit_cnt + IDX_W'(1);
            if (bit_cnt == last_idx) begin
              state <= cfg_q.pen ? PARITY : STOP1;
            end
          end
          PARITY: begin
            par_q <= bus.bit_in;
            state <= STOP1;
          end
          STOP1: begin
            // Shift register was cleared at the start bit, so unused upper
            // bits read as zero both in rx_data and in the break test.
            fv_q   <= 1'b1;
            data_q <= shift_q;
            fe_q   <= ~bus.bit_in;
            pe_q   <= cfg_q.pen & (par_q != exp_par);
            bi_q   <= (shift_q == '0) & (~cfg_q.pen | ~par_q) & ~bus.bit_in;
            if (cfg_q.stb) begin
              state <= STOP2;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          STOP2: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [CNT_W-1:0] pe_cnt;
  logic [CNT_W-1:0] fe_cnt;

  err_sat_counter #(.CNT_W(CNT_W)) u_pe_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fv_q & pe_q),
    .clr   (bus.cnt_clr),
    .count (pe_cnt)
  );

  err_sat_counter #(.CNT_W(CNT_W)) u_fe_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fv_q & fe_q),
    .clr   (bus.cnt_clr),
    .count (fe_cnt)
  );

  assign bus.busy          = busy_q;
  assign bus.frame_valid   = fv_q;
  assign bus.rx_data       = data_q;
  assign bus.parity_error  = pe_q;
  assign bus.framing_error = fe_q;
  assign bus.break_int     = bi_q;
  assign bus.pe_count      = pe_cnt;
  assign bus.fe_count      = fe_cnt;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Self-checking bench for uart_rx_frame_checker: table of frames driven bit by
// bit, expected results queued at the stop bit and compared on frame_valid.
module tb_uart_rx_frame_checker;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_checker_if #(.MAX_DATA_W(8), .CNT_W(8)) bus ();

  uart_rx_frame_checker #(.MAX_DATA_W(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    rx_cfg_t    cfg;
    logic [7:0] data;
    logic       par;
    logic       stop1;
    logic       stop2;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_bi;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   model_pe = 0;
  int   model_fe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int wls, input int stb, input int pen,
                              input int eps, input int sp, input int data,
                              input int par, input int s1, input int s2,
                              input int ed, input int pe, input int fe,
                              input int bi);
    vec_t v;
    v.cfg.wls  = 2'(wls);
    v.cfg.stb  = 1'(stb);
    v.cfg.pen  = 1'(pen);
    v.cfg.eps  = 1'(eps);
    v.cfg.sp   = 1'(sp);
    v.data     = 8'(data);
    v.par      = 1'(par);
    v.stop1    = 1'(s1);
    v.stop2    = 1'(s2);
    v.exp_data = 8'(ed);
    v.exp_pe   = 1'(pe);
    v.exp_fe   = 1'(fe);
    v.exp_bi   = 1'(bi);
    return v;
  endfunction

  // Monitor: every frame_valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_frame_valid", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        check("parity_error", 32'(bus.parity_error), 32'(e.pe));
        check("framing_error", 32'(bus.framing_error), 32'(e.fe));
        check("break_int", 32'(bus.break_int), 32'(e.bi));
        check("frame_valid_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  // All driver tasks start and end on a falling edge.
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.bit_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic strobe(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    @(negedge clk);
    bus.bit_valid = 1'b0;
  endtask

  task automatic set_cfg(input rx_cfg_t c);
    bus.wls = c.wls;
    bus.stb = c.stb;
    bus.pen = c.pen;
    bus.eps = c.eps;
    bus.sp  = c.sp;
  endtask

  task automatic send_frame(input vec_t v, input bit clr_at_fv);
    int   nb;
    exp_t e;
    nb = 5 + int'(v.cfg.wls);
    set_cfg(v.cfg);
    gap();
    strobe(1'b0);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    // Scramble the live config; the latched copy must govern the frame.
    bus.wls = 2'($urandom_range(0, 3));
    bus.stb = 1'($urandom_range(0, 1));
    bus.pen = 1'($urandom_range(0, 1));
    bus.eps = 1'($urandom_range(0, 1));
    bus.sp  = 1'($urandom_range(0, 1));
    for (int i = 0; i < nb; i++) begin
      gap();
      strobe(v.data[i]);
    end
    if (v.cfg.pen) begin
      gap();
      strobe(v.par);
    end
    gap();
    e.data = v.exp_data;
    e.pe   = v.exp_pe;
    e.fe   = v.exp_fe;
    e.bi   = v.exp_bi;
    e.due  = cyc + 1;
    sb_q.push_back(e);
    strobe(v.stop1);
    check("busy_after_stop1", 32'(bus.busy), 32'(v.cfg.stb));
    if (clr_at_fv) begin
      bus.cnt_clr = 1'b1;
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      model_pe = 0;
      model_fe = 0;
    end else begin
      if (v.exp_pe && model_pe < 255) model_pe++;
      if (v.exp_fe && model_fe < 255) model_fe++;
    end
    if (v.cfg.stb) begin
      gap();
      strobe(v.stop2);
      check("busy_after_stop2", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    check("frame_produced", 32'(sb_q.size()), 32'd0);
    check("pe_count", 32'(bus.pe_count), 32'(model_pe));
    check("fe_count", 32'(bus.fe_count), 32'(model_fe));
  endtask

  initial begin
    vec_t sat_v;

    //              wls stb pen eps sp  data   par s1 s2  exp    pe fe bi
    vecs[0]  = mk(3, 0, 0, 0, 0, 'hA5, 0, 1, 1, 'hA5, 0, 0, 0);  // 8N1
    vecs[1]  = mk(3, 0, 1, 1, 0, 'h07, 0, 1, 1, 'h07, 1, 0, 0);  // 8E1 bad par
    vecs[2]  = mk(3, 0, 1, 1, 0, 'h07, 1, 1, 1, 'h07, 0, 0, 0);  // 8E1 good par
    vecs[3]  = mk(0, 0, 1, 0, 1, 'hFF, 1, 1, 1, 'h1F, 0, 0, 0);  // 5 stick good
    vecs[4]  = mk(0, 0, 1, 0, 1, 'hFF, 0, 1, 1, 'h1F, 1, 0, 0);  // 5 stick bad
    vecs[5]  = mk(3, 0, 1, 0, 0, 'h00, 0, 0, 1, 'h00, 1, 1, 1);  // 8O1 break
    vecs[6]  = mk(2, 1, 1, 0, 0, 'h55, 1, 1, 0, 'h55, 0, 0, 0);  // 7O2 stop2=0
    vecs[7]  = mk(1, 0, 0, 0, 0, 'h2A, 0, 0, 1, 'h2A, 0, 1, 0);  // 6N1 FE only
    vecs[8]  = mk(3, 0, 1, 1, 0, 'h00, 0, 0, 1, 'h00, 0, 1, 1);  // 8E1 break
    vecs[9]  = mk(3, 0, 0, 0, 0, 'h00, 0, 0, 1, 'h00, 0, 1, 1);  // 8N1 break
    vecs[10] = mk(3, 1, 1, 1, 1, 'h80, 0, 1, 1, 'h80, 0, 0, 0);  // 8 stick0 2 stop

    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b1;
    bus.wls       = 2'b00;
    bus.stb       = 1'b0;
    bus.pen       = 1'b0;
    bus.eps       = 1'b0;
    bus.sp        = 1'b0;
    bus.cnt_clr   = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);

    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("reset_rx_data", 32'(bus.rx_data), 32'd0);
    check("reset_flags", 32'({bus.parity_error, bus.framing_error, bus.break_int}), 32'd0);
    check("reset_counts", 32'({bus.pe_count, bus.fe_count}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) send_frame(vecs[i], 1'b0);

    // Reset three data bits into an 8N1 frame: abort with no frame_valid.
    set_cfg(vecs[0].cfg);
    strobe(1'b0);
    repeat (3) strobe(1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_pe = 0;
    model_fe = 0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("abort_rx_data", 32'(bus.rx_data), 32'd0);
    check("abort_flags", 32'({bus.parity_error, bus.framing_error, bus.break_int}), 32'd0);
    check("abort_counts", 32'({bus.pe_count, bus.fe_count}), 32'd0);
    repeat (6) strobe(1'b1);
    repeat (3) @(negedge clk);
    check("abort_no_frame", 32'(sb_q.size()), 32'd0);
    send_frame(vecs[0], 1'b0);

    // 300 framing errors saturate the 8-bit counter, then clear on frame_valid.
    sat_v = mk(3, 0, 0, 0, 0, 'h01, 0, 0, 1, 'h01, 0, 1, 0);
    repeat (300) send_frame(sat_v, 1'b0);
    check("fe_count_saturated", 32'(bus.fe_count), 32'd255);
    send_frame(sat_v, 1'b1);
    check("fe_count_clr_priority", 32'(bus.fe_count), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
- Serial, parametrised successor to the combinational UART parity check.
- Consumes one sampled bit per `bit_valid` strobe from the RX bit sampler and tracks the frame with an FSM: start, 5..MAX_DATA_W data bits, optional parity, 1 or 2 stop bits.
- Accumulates parity on the fly and flags parity, framing and break errors per frame.
- Keeps saturating per-error counters. Sits between the RX sampler and the RX FIFO/LSR logic.

Parameters:
- MAX_DATA_W, 8, widest data word supported; `wls` selects 5..8, and MAX_DATA_W must be ≥8.
- CNT_W, 8, width of each saturating error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- bit_valid  in  1  one-cycle strobe: `bit_in` holds a mid-bit sample
- bit_in  in  1  sampled RX line value
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits
- stb  in  1  0 = one stop bit, 1 = two stop bits
- pen  in  1  parity enable
- eps  in  1  even parity select
- sp  in  1  stick parity
- cnt_clr  in  1  clear both error counters
- busy  out  1  high from start bit until the frame is fully consumed
- frame_valid  out  1  one-cycle pulse: `rx_data` and flags are new
- rx_data  out  MAX_DATA_W  received data, LSB first; unused upper bits are 0
- parity_error  out  1  valid with/after `frame_valid`
- framing_error  out  1  first stop bit sampled 0
- break_int  out  1  all data bits, parity (if enabled) and first stop bit are 0
- pe_count  out  CNT_W  saturating parity-error count
- fe_count  out  CNT_W  saturating framing-error count

Behaviour:
- Reset: FSM to IDLE. All outputs 0, including counters, `rx_data` and flags.
- Only cycles with `bit_valid`=1 advance the FSM; other cycles hold state.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
  - IDLE: `bit_valid`&`bit_in`=0 → DATA. On that cycle latch `wls`/`stb`/`pen`/`eps`/`sp`, clear the shift register, parity accumulator and bit counter, and set `busy`=1. `bit_in`=1 in IDLE is ignored.
  - DATA: store `bit_in` at index = bit counter and XOR it into the accumulator. After the last data bit (count = `wls`+4): → PARITY if latched `pen`, else → STOP1.
  - PARITY: capture the received parity bit; → STOP1.
  - STOP1: evaluate the frame.
    - `framing_error` = ~`bit_in`.
    - Expected parity = `sp` ? ~`eps` : (`eps` ? acc : ~acc).
    - `parity_error` = `pen` & (received ≠ expected).
    - `break_int` = (data==0) & (~`pen` | parity bit==0) & ~`bit_in`.
    - Next state: → STOP2 if latched `stb`, else → IDLE with `busy`=0.
  - STOP2: consume one bit, unchecked; → IDLE, `busy`=0.
- Latency: `frame_valid` pulses exactly one cycle after the STOP1 `bit_valid` cycle. `rx_data` and all flags update in that same cycle and hold until the next `frame_valid`.
- A framing error does not resync. A 0 on the next strobe after returning to IDLE is a new start bit.
- Config changes mid-frame have no effect; the values latched at the start bit apply.
- Counters:
  - Each counter increments on `frame_valid`, when its flag is set.
  - They saturate at 2^CNT_W−1.
  - `cnt_clr` takes priority over a simultaneous increment, so the result is 0.
- `rst` mid-frame: immediate abort to IDLE. No `frame_valid` is emitted and all outputs return to reset values.

Decomposition:
- Package `uart_rx_pkg` holds:
  - the state enum;
  - word-length decode constants (WLS_5..WLS_8);
  - a function mapping `wls` to a data-bit count;
  - the expected-parity function (`sp`/`eps`/acc).
- One natural sub-module: `err_sat_counter` (CNT_W, inc, clr), instantiated twice.

Test Plan:
- 8N1, data 0xA5 LSB-first, stop=1 → `frame_valid` 1 cycle after the stop strobe; `rx_data`=0xA5; PE=FE=BI=0; counters remain 0.
- 8E1 (`pen`=1, `eps`=1), data 0x07 with parity bit 0 (wrong) → `parity_error`=1, `pe_count`=1. Repeat with parity bit 1 → `parity_error`=0, `pe_count` stays 1.
- 5 data bits with stick parity (`wls`=00, `pen`=1, `sp`=1, `eps`=0), data 0x1F, parity bit 1 → `rx_data`=0x1F (upper bits 0), no PE. Repeat with parity bit 0 → PE=1.
- Break: all strobes 0 (start, 8 data bits, parity bit of 8O1, stop) → BI=1, FE=1, `fe_count`=1. The next strobe 0 starts a new frame (`busy`=1).
- 7O2 with a second stop bit of 0 → no FE; `busy` stays high through STOP2 and `frame_valid` occurs only once. `rst` asserted after 3 data bits → `busy`=0, no `frame_valid`, outputs 0.
- Force 300 framing errors with CNT_W=8 → `fe_count` saturates at 255. Assert `cnt_clr` in the same cycle as an FE `frame_valid` → `fe_count`=0.
